// File: rtl/fifo_rd_sched.sv
// Round-robin read scheduler that shares one async-FIFO read port among NREQ consumers.
// Optional FIFO_RD_SCHED_EMPTY_TERM_EN: an empty FIFO ends a burst once at least one word has been popped.
module fifo_rd_sched #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 8,
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [NREQ-1:0]  req,
  input  logic             fifo_rempty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             rinc,
  output logic [NREQ-1:0]  gnt,
  output logic [DSIZE-1:0] dout,
  output logic [NREQ-1:0]  dvalid,
  output logic             busy,
  output logic [CW-1:0]    burst_cnt
);

  localparam int OW = $clog2(NREQ);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BURST);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [OW:0]   NREQ_W   = (OW + 1)'(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, BURST, DONE} state_e;

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  dvalid_q, dvalid_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_q, last_d;
  logic [DSIZE-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    winner;
  logic             winner_found;
  logic [OW:0]      scan_sum;
  logic             rinc_c;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    scan_sum     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_sum = {1'b0, last_q} + (OW + 1)'(i);
      if (scan_sum >= NREQ_W) scan_sum = scan_sum - NREQ_W;
      if (!winner_found && req[scan_sum[OW-1:0]]) begin
        winner_found = 1'b1;
        winner       = scan_sum[OW-1:0];
      end
    end
  end

  assign rinc_c = (state_q == BURST) && req[owner_q] && !fifo_rempty && (cnt_q < MAX_CNT);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    dvalid_d = '0;
    owner_d  = owner_q;
    last_d   = last_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (winner_found && !fifo_rempty) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << winner;
          owner_d = winner;
        end
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = BURST;
      end
      BURST: begin
        if (rinc_c) begin
          dout_d   = fifo_rdata;
          dvalid_d = gnt_q;
          cnt_d    = cnt_q + CW'(1);
        end
        // An owner release takes priority over an empty stall.
        if (!req[owner_q]) begin
          state_d = DONE;
        end else if (rinc_c && (cnt_q == LAST_CNT)) begin
          state_d = DONE;
`ifdef FIFO_RD_SCHED_EMPTY_TERM_EN
        end else if (fifo_rempty && (cnt_q != '0)) begin
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        gnt_d   = '0;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      dvalid_q <= '0;
      owner_q  <= '0;
      last_q   <= OW'(NREQ - 1);
      dout_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      dvalid_q <= dvalid_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rinc      = rinc_c;
  assign gnt       = gnt_q;
  assign dout      = dout_q;
  assign dvalid    = dvalid_q;
  assign busy      = (state_q != IDLE);
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: a queue models the FIFO, and a scoreboard holds the expected dout/dvalid.
// Expectations cover both builds of FIFO_RD_SCHED_EMPTY_TERM_EN.
module tb_fifo_rd_sched;
  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 8;
  localparam int CW        = $clog2(MAX_BURST + 1);

  logic             rclk = 1'b0;
  logic             rrst;
  logic [NREQ-1:0]  req;
  logic             fifo_rempty;
  logic [DSIZE-1:0] fifo_rdata;
  logic             rinc;
  logic [NREQ-1:0]  gnt;
  logic [DSIZE-1:0] dout;
  logic [NREQ-1:0]  dvalid;
  logic             busy;
  logic [CW-1:0]    burst_cnt;

  typedef struct packed {
    logic [NREQ-1:0]  v;
    logic [DSIZE-1:0] d;
  } sb_t;

  sb_t              sb[$];
  logic [DSIZE-1:0] fifo_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int exp_owner    = 0;
  int pops;
  int first_idx;
  int last_idx;
  bit rinc_seen;

  fifo_rd_sched #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .rclk(rclk), .rrst(rrst), .req(req), .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
    .rinc(rinc), .gnt(gnt), .dout(dout), .dvalid(dvalid), .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_rempty = (fifo_q.size() == 0);
    fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic applyStimulus(input int n, input logic [DSIZE-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DSIZE'(i));
    update_fifo();
  endtask

  // One clock: compare last cycle's pop at the negedge, then let the FIFO model react to this cycle's rinc.
  task automatic checkOutput();
    sb_t e;
    @(negedge rclk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("dvalid", dvalid, e.v);
      check("dout", dout, e.d);
    end else begin
      check("dvalid_idle", dvalid, 0);
    end
    rinc_seen = rinc;
    if (rinc) begin
      check("rinc_nonempty", fifo_rempty, 0);
      check("gnt_owner", gnt, NREQ'(1) << exp_owner);
      e.v = NREQ'(1) << exp_owner;
      e.d = fifo_rdata;
      sb.push_back(e);
    end
    @(posedge rclk);
    #1;
    if (rinc_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    update_fifo();
  endtask

  task automatic run_burst(input int owner, input int n, input int budget);
    exp_owner = owner;
    pops      = 0;
    first_idx = -1;
    last_idx  = -1;
    for (int c = 0; c < budget && pops < n; c++) begin
      checkOutput();
      if (rinc_seen) begin
        if (first_idx < 0) first_idx = c;
        last_idx = c;
        pops++;
      end
    end
    check("burst_pops", pops, n);
  endtask

  initial begin
    int order[6] = '{0, 1, 3, 0, 1, 3};
    rrst = 1'b1;
    req  = '0;
    update_fifo();
    repeat (2) @(posedge rclk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_dout", dout, 0);
    check("rst_cnt", burst_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_rinc", rinc, 0);
    @(posedge rclk);
    #1 rrst = 1'b0;

    // Requests with an empty FIFO must never leave IDLE.
    req = 4'hF;
    repeat (10) begin
      checkOutput();
      check("idle_gnt", gnt, 0);
      check("idle_busy", busy, 0);
      check("idle_rinc", rinc, 0);
    end

    req = '0;
    applyStimulus(20, 8'h10);
    req = 4'b0001;
    run_burst(0, 8, 40);
    check("full_latency", first_idx, 2);
    check("full_consec", last_idx - first_idx, 7);
    run_burst(0, 8, 40);
    check("regrant_gap", first_idx, 3);
    check("regrant_consec", last_idx - first_idx, 7);
    req = '0;
    repeat (3) checkOutput();
    check("full_left", fifo_q.size(), 4);
    check("full_end_busy", busy, 0);
    fifo_q.delete();
    update_fifo();

    applyStimulus(10, 8'h40);
    req = 4'b0100;
    run_burst(2, 3, 20);
    req = '0;
    checkOutput();
    check("drop_no_rinc", rinc_seen, 0);
    check("drop_cnt", burst_cnt, 3);
    check("drop_done_busy", busy, 1);
    checkOutput();
    check("drop_idle_busy", busy, 0);
    check("drop_idle_gnt", gnt, 0);
    check("drop_left", fifo_q.size(), 7);
    fifo_q.delete();
    update_fifo();

    applyStimulus(2, 8'h60);
    req = 4'b0011;
    run_burst(0, 2, 20);
    repeat (4) begin
      checkOutput();
      check("stall_rinc", rinc_seen, 0);
    end
`ifndef FIFO_RD_SCHED_EMPTY_TERM_EN
    check("stall_gnt", gnt, 4'b0001);
    check("stall_busy", busy, 1);
    check("stall_cnt", burst_cnt, 2);
    applyStimulus(3, 8'h70);
    run_burst(0, 3, 10);
    check("resume_latency", first_idx, 0);
`else
    check("term_gnt", gnt, 0);
    check("term_busy", busy, 0);
    applyStimulus(3, 8'h70);
    run_burst(1, 3, 10);
    check("term_regrant", first_idx, 2);
`endif
    req = '0;
    repeat (3) checkOutput();
    check("stall_end_busy", busy, 0);

    // Async reset in the middle of a burst, while rinc is high.
    applyStimulus(10, 8'h80);
    req = 4'b0100;
    run_burst(2, 3, 20);
    #2 rrst = 1'b1;
    #1;
    check("midrst_rinc", rinc, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_dvalid", dvalid, 0);
    check("midrst_cnt", burst_cnt, 0);
    check("midrst_busy", busy, 0);
    sb.delete();
    @(posedge rclk);
    #1 rrst = 1'b0;
    fifo_q.delete();
    applyStimulus(50, 8'h90);

    req = 4'b1011;
    for (int b = 0; b < 6; b++) begin
      run_burst(order[b], 8, 20);
      check("rr_latency", first_idx, (b == 0) ? 2 : 3);
      check("rr_consec", last_idx - first_idx, 7);
    end
    req = '0;
    repeat (3) checkOutput();
    check("rr_end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
